// File: rtl/rx_to_mem_pkg.sv
// rx_to_mem_pkg: shared definitions for the serial-to-matrix loader.
//   - Receiver and writer state encodings.
//   - Oversampling constants and memory address width.
// Optional feature macro: RX_PARITY_EN (adds the even-parity receive state).
package rx_to_mem_pkg;

    localparam int unsigned OVERSAMPLE = 8;  // ticks per bit time
    localparam int unsigned MID_SAMPLE = 4;  // ticks from start edge to mid start bit
    localparam int unsigned ADDR_W     = 6;  // memory address width

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef RX_PARITY_EN
        R_PARITY,
`endif
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WRITE,
        DONE
    } wr_state_t;

endpackage

// File: rtl/rx_to_mem_uart_rx.sv
// uart_rx: 8x oversampling UART receiver (8N1, or 8E1 with RX_PARITY_EN).
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-low reset
//   rx_data         in   asynchronous serial line, idle high
//   byte_valid      out  one-cycle strobe, byte_data holds a good byte
//   byte_data       out  last received byte
//   frame_err_pulse out  one-cycle strobe on bad stop (or parity) bit
// Optional feature macro: RX_PARITY_EN.
module uart_rx
    import rx_to_mem_pkg::*;
#(
    parameter int unsigned OVS_DIV = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse
);

    localparam int unsigned DIV_W    = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [2:0]  LAST_SMP = 3'(OVERSAMPLE - 1);
    localparam logic [2:0]  MID_SMP  = 3'(MID_SAMPLE - 1);

    logic             sync1, line;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    rx_state_t  state, state_n;
    logic [2:0] smp_cnt, smp_cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n;
    logic       valid_n, ferr_n;
    logic [7:0] data_n;
`ifdef RX_PARITY_EN
    logic       par_bad, par_bad_n;
`endif

    assign tick = (div_cnt == DIV_W'(OVS_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1           <= 1'b1;
            line            <= 1'b1;
            div_cnt         <= '0;
            state           <= R_IDLE;
            smp_cnt         <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            byte_valid      <= 1'b0;
            byte_data       <= '0;
            frame_err_pulse <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad         <= 1'b0;
`endif
        end else begin
            sync1           <= rx_data;
            line            <= sync1;
            div_cnt         <= tick ? '0 : div_cnt + 1'b1;
            state           <= state_n;
            smp_cnt         <= smp_cnt_n;
            bit_idx         <= bit_idx_n;
            shift           <= shift_n;
            byte_valid      <= valid_n;
            byte_data       <= data_n;
            frame_err_pulse <= ferr_n;
`ifdef RX_PARITY_EN
            par_bad         <= par_bad_n;
`endif
        end
    end

    // smp_cnt is zeroed at the mid-start sample, so every later sample
    // lands on its 3-bit wrap: exactly one bit time apart, mid-bit.
    always_comb begin
        state_n   = state;
        smp_cnt_n = smp_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        data_n    = byte_data;
        ferr_n    = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_n = par_bad;
`endif
        if (tick) begin
            case (state)
                R_IDLE: begin
                    if (!line) begin
                        state_n   = R_START;
                        smp_cnt_n = '0;
                    end
                end
                R_START: begin
                    if (smp_cnt == MID_SMP) begin
                        smp_cnt_n = '0;
                        bit_idx_n = '0;
                        state_n   = line ? R_IDLE : R_DATA;
                    end else begin
                        smp_cnt_n = smp_cnt + 3'd1;
                    end
                end
                R_DATA: begin
                    smp_cnt_n = smp_cnt + 3'd1;
                    if (smp_cnt == LAST_SMP) begin
                        shift_n   = {line, shift[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                            state_n = R_PARITY;
`else
                            state_n = R_STOP;
`endif
                        end
                    end
                end
`ifdef RX_PARITY_EN
                R_PARITY: begin
                    smp_cnt_n = smp_cnt + 3'd1;
                    if (smp_cnt == LAST_SMP) begin
                        par_bad_n = line ^ (^shift);
                        state_n   = R_STOP;
                    end
                end
`endif
                R_STOP: begin
                    smp_cnt_n = smp_cnt + 3'd1;
                    if (smp_cnt == LAST_SMP) begin
                        state_n = R_IDLE;
`ifdef RX_PARITY_EN
                        if (line && !par_bad) begin
`else
                        if (line) begin
`endif
                            valid_n = 1'b1;
                            data_n  = shift;
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end
                end
                default: state_n = R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rx_to_mem.sv
// rx_to_mem: receives UART bytes and writes them row-major into a
// ROW x COLUMN matrix memory; one load edge captures ROW*COLUMN bytes.
// Ports:
//   clk, rst       system clock; synchronous active-low reset
//   rx_data        serial input, idle high
//   load           level; rising edge arms (or restarts) a capture
//   write          one-cycle memory write strobe
//   write_address  row-major address r*COLUMN+c
//   write_value    byte to write
//   busy           high from arm until the final write
//   done           one-cycle pulse the cycle after the final write
//   frame_err      sticky receive error, cleared on arm
// Optional feature macro: RX_PARITY_EN (even parity after D7).
module rx_to_mem
    import rx_to_mem_pkg::*;
#(
    parameter int unsigned ROW     = 2,
    parameter int unsigned COLUMN  = 2,
    parameter int unsigned OVS_DIV = 651
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_data,
    input  logic              load,
    output logic              write,
    output logic [ADDR_W-1:0] write_address,
    output logic [7:0]        write_value,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(ROW * COLUMN);

    logic       byte_valid, frame_err_pulse;
    logic [7:0] byte_data;

    uart_rx #(.OVS_DIV(OVS_DIV)) u_rx (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .frame_err_pulse (frame_err_pulse)
    );

    logic load_r1, load_r2, load_r3, load_pulse;
    assign load_pulse = load_r2 & ~load_r3;

    wr_state_t         state, state_n;
    logic [ADDR_W:0]   count, count_n, count_inc;
    logic              write_n, busy_n, done_n, ferr_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        value_n;

    assign count_inc = count + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            load_r1       <= 1'b0;
            load_r2       <= 1'b0;
            load_r3       <= 1'b0;
            state         <= IDLE;
            count         <= '0;
            write         <= 1'b0;
            write_address <= '0;
            write_value   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            load_r1       <= load;
            load_r2       <= load_r1;
            load_r3       <= load_r2;
            state         <= state_n;
            count         <= count_n;
            write         <= write_n;
            write_address <= addr_n;
            write_value   <= value_n;
            busy          <= busy_n;
            done          <= done_n;
            frame_err     <= ferr_n;
        end
    end

    // Arming clears the sticky error, but an error strobe in the same
    // cycle still registers so it is never lost.
    always_comb begin
        state_n = state;
        count_n = count;
        write_n = 1'b0;
        addr_n  = write_address;
        value_n = write_value;
        busy_n  = busy;
        done_n  = 1'b0;
        ferr_n  = frame_err | frame_err_pulse;
        case (state)
            IDLE, ARMED: begin
                if (load_pulse) begin
                    state_n = ARMED;
                    count_n = '0;
                    busy_n  = 1'b1;
                    ferr_n  = frame_err_pulse;
                end else if (state == ARMED && byte_valid) begin
                    state_n = WRITE;
                    write_n = 1'b1;
                    addr_n  = count[ADDR_W-1:0];
                    value_n = byte_data;
                end
            end
            WRITE: begin
                count_n = count_inc;
                if (count_inc == CELLS) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n = ARMED;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_to_mem.sv
// tb_rx_to_mem: randomized self-checking bench for rx_to_mem with
// ROW=COLUMN=2 and OVS_DIV=4 (one bit time = 32 clocks).
// Optional feature macro: RX_PARITY_EN (bench sends and checks parity).
module tb_rx_to_mem;

    localparam int unsigned ROW      = 2;
    localparam int unsigned COLUMN   = 2;
    localparam int unsigned OVS_DIV  = 4;
    localparam int unsigned CELLS    = ROW * COLUMN;
    localparam int unsigned BIT_CLKS = OVS_DIV * 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_data = 1'b1;
    logic       load = 1'b0;
    logic       write, busy, done, frame_err;
    logic [5:0] write_address;
    logic [7:0] write_value;

    rx_to_mem #(.ROW(ROW), .COLUMN(COLUMN), .OVS_DIV(OVS_DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .load          (load),
        .write         (write),
        .write_address (write_address),
        .write_value   (write_value),
        .busy          (busy),
        .done          (done),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Observed bus activity, sampled on the falling edge.
    int cyc = 0;
    int obs_addr[$], obs_val[$], obs_wcyc[$], done_cyc[$], done_busy[$];

    always @(negedge clk) begin
        cyc++;
        if (write === 1'b1) begin
            obs_addr.push_back(int'(write_address));
            obs_val.push_back(int'(write_value));
            obs_wcyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(int'(busy));
        end
    end

    // Reference model: a load session fills CELLS consecutive addresses with
    // good bytes; bad frames only raise the error; idle bytes are ignored.
    bit m_armed = 0;
    int m_count = 0;
    bit m_ferr = 0;
    int exp_addr[$], exp_val[$];
    int exp_done = 0;

    task automatic model_reset();
        m_armed = 0; m_count = 0; m_ferr = 0;
    endtask

    task automatic model_arm();
        m_armed = 1; m_count = 0; m_ferr = 0;
    endtask

    task automatic model_frame(input int b, input bit good);
        if (!good) begin
            m_ferr = 1;
        end else if (m_armed) begin
            exp_addr.push_back(m_count);
            exp_val.push_back(b);
            m_count++;
            if (m_count == CELLS) begin
                m_armed = 0;
                exp_done++;
            end
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_addr.delete(); obs_val.delete(); obs_wcyc.delete();
        done_cyc.delete(); done_busy.delete();
        exp_addr.delete(); exp_val.delete(); exp_done = 0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        clk_wait(4);
        load = 1'b0;
        clk_wait(2);
        model_arm();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit par_ok, input int gap_bits);
        rx_data = 1'b0;
        clk_wait(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            clk_wait(BIT_CLKS);
        end
`ifdef RX_PARITY_EN
        rx_data = (^b) ^ !par_ok;
        clk_wait(BIT_CLKS);
        model_frame(int'(b), stop_ok && par_ok);
`else
        model_frame(int'(b), stop_ok);
`endif
        rx_data = stop_ok;
        clk_wait(BIT_CLKS);
        rx_data = 1'b1;
        clk_wait(gap_bits * BIT_CLKS);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clk_wait(3);
        vectors++;
        if ({write, write_address, write_value, busy, done, frame_err} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got w=%b a=%0d v=%02h busy=%b done=%b ferr=%b, want all 0",
                     write, write_address, write_value, busy, done, frame_err);
        end
        rst = 1'b1;
        model_reset();
        clk_wait(2 * BIT_CLKS);
    endtask

    task automatic test_basic();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        clear_logs();
        pulse_load();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_armed: got %b want 1", busy);
        end
        for (int i = 0; i < 4; i++) send_frame(bytes[i], 1, 1, (i == 3) ? 1 : 0);
        vectors++;
        if (obs_addr.size() !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_val[i] !== exp_val[i]) begin
                miscompares++;
                $display("FAIL basic_write%0d: got (%0d,%02h) want (%0d,%02h)",
                         i, obs_addr[i], obs_val[i], exp_addr[i], exp_val[i]);
            end
        end
        vectors++;
        if (done_cyc.size() !== exp_done) begin
            miscompares++;
            $display("FAIL basic_done_count: got %0d want %0d", done_cyc.size(), exp_done);
        end else if (obs_wcyc.size() == CELLS) begin
            vectors++;
            if (done_cyc[0] !== obs_wcyc[CELLS-1] + 1 || done_busy[0] !== 0) begin
                miscompares++;
                $display("FAIL basic_done_timing: got done@%0d busy=%0d want done@%0d busy=0",
                         done_cyc[0], done_busy[0], obs_wcyc[CELLS-1] + 1);
            end
        end
    endtask

    task automatic test_bad_stop();
        clear_logs();
        pulse_load();
        send_frame(8'($urandom), 1, 1, 0);
        send_frame(8'hA5, 0, 1, 2);
        send_frame(8'h5A, 1, 1, 0);
        send_frame(8'($urandom), 1, 1, 0);
        send_frame(8'($urandom), 1, 1, 1);
        vectors++;
        if (obs_addr.size() !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL badstop_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_val[i] !== exp_val[i]) begin
                miscompares++;
                $display("FAIL badstop_write%0d: got (%0d,%02h) want (%0d,%02h)",
                         i, obs_addr[i], obs_val[i], exp_addr[i], exp_val[i]);
            end
        end
        vectors++;
        if (frame_err !== m_ferr || done_cyc.size() !== exp_done) begin
            miscompares++;
            $display("FAIL badstop_flags: got ferr=%b dones=%0d want ferr=%b dones=%0d",
                     frame_err, done_cyc.size(), m_ferr, exp_done);
        end
    endtask

    task automatic test_idle_drop();
        clear_logs();
        send_frame(8'hFF, 1, 1, 1);
        vectors++;
        if (obs_addr.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_drop: got %0d writes busy=%b want 0 writes busy=0", obs_addr.size(), busy);
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        pulse_load();
        rx_data = 1'b0;
        clk_wait(2 * OVS_DIV);
        rx_data = 1'b1;
        clk_wait(3 * BIT_CLKS);
        vectors++;
        if (obs_addr.size() !== 0 || frame_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch: got %0d writes ferr=%b busy=%b want 0 writes ferr=0 busy=1",
                     obs_addr.size(), frame_err, busy);
        end
    endtask

    task automatic test_reload();
        clear_logs();
        pulse_load();
        send_frame(8'($urandom), 1, 1, 0);
        send_frame(8'($urandom), 1, 1, 1);
        pulse_load();
        for (int i = 0; i < CELLS; i++) send_frame(8'($urandom), 1, 1, 0);
        clk_wait(BIT_CLKS);
        vectors++;
        if (obs_addr.size() !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL reload_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            vectors++;
            if (obs_addr[i] !== exp_addr[i] || obs_val[i] !== exp_val[i]) begin
                miscompares++;
                $display("FAIL reload_write%0d: got (%0d,%02h) want (%0d,%02h)",
                         i, obs_addr[i], obs_val[i], exp_addr[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        clear_logs();
        pulse_load();
        send_frame(8'($urandom) | 8'h01, 1, 1, 0);
        rx_data = 1'b0;
        clk_wait(3 * BIT_CLKS);
        rst = 1'b0;
        clk_wait(1);
        rst = 1'b1;
        rx_data = 1'b1;
        model_reset();
        vectors++;
        if ({write, write_address, write_value, busy, done, frame_err} !== 18'd0) begin
            miscompares++;
            $display("FAIL resetmid_outputs: got w=%b a=%0d v=%02h busy=%b done=%b ferr=%b, want all 0",
                     write, write_address, write_value, busy, done, frame_err);
        end
        clk_wait(2 * BIT_CLKS);
        clear_logs();
        pulse_load();
        b = 8'($urandom);
        send_frame(b, 1, 1, 1);
        vectors++;
        if (obs_addr.size() !== 1 || exp_addr.size() !== 1) begin
            miscompares++;
            $display("FAIL resetmid_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
        end else begin
            vectors++;
            if (obs_addr[0] !== exp_addr[0] || obs_val[0] !== exp_val[0]) begin
                miscompares++;
                $display("FAIL resetmid_write: got (%0d,%02h) want (%0d,%02h)",
                         obs_addr[0], obs_val[0], exp_addr[0], exp_val[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            pulse_load();
            while (m_armed) begin
                if ($urandom_range(4) == 0) send_frame(8'($urandom), 0, 1, 2);
                else send_frame(8'($urandom), 1, 1, int'($urandom_range(1)));
            end
            clk_wait(BIT_CLKS);
            vectors++;
            if (obs_addr.size() !== exp_addr.size()) begin
                miscompares++;
                $display("FAIL random%0d_count: got %0d writes want %0d", r, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                vectors++;
                if (obs_addr[i] !== exp_addr[i] || obs_val[i] !== exp_val[i]) begin
                    miscompares++;
                    $display("FAIL random%0d_write%0d: got (%0d,%02h) want (%0d,%02h)",
                             r, i, obs_addr[i], obs_val[i], exp_addr[i], exp_val[i]);
                end
            end
            vectors++;
            if (frame_err !== m_ferr || done_cyc.size() !== exp_done || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL random%0d_flags: got ferr=%b dones=%0d busy=%b want ferr=%b dones=%0d busy=0",
                         r, frame_err, done_cyc.size(), busy, m_ferr, exp_done);
            end
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        clear_logs();
        pulse_load();
        send_frame(8'h03, 1, 0, 1);
        vectors++;
        if (frame_err !== 1'b1 || obs_addr.size() !== 0) begin
            miscompares++;
            $display("FAIL parity_bad: got ferr=%b writes=%0d want ferr=1 writes=0", frame_err, obs_addr.size());
        end
        send_frame(8'h03, 1, 1, 1);
        vectors++;
        if (obs_addr.size() !== 1 || exp_addr.size() !== 1) begin
            miscompares++;
            $display("FAIL parity_good_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
        end else begin
            vectors++;
            if (obs_addr[0] !== exp_addr[0] || obs_val[0] !== exp_val[0]) begin
                miscompares++;
                $display("FAIL parity_good_write: got (%0d,%02h) want (%0d,%02h)",
                         obs_addr[0], obs_val[0], exp_addr[0], exp_val[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_stop();
        test_idle_drop();
        test_glitch();
        test_reload();
        test_reset_mid();
        test_random();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
